// File: rtl/vdc_sync_analyzer.sv
// Video timing analyzer: measures line/field geometry from VDC sync and
// blanking, publishes one measurement set per vsync and tracks lock.
module vdc_sync_analyzer #(
  parameter int unsigned LOCK_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable0,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        hblank,
  input  logic        vblank,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [11:0] h_sync_w,
  output logic [10:0] v_total,
  output logic [10:0] v_active,
  output logic [10:0] v_sync_w,
  output logic        field,
  output logic        interlaced,
  output logic        locked,
  output logic        frame_stb
);

  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [11:0] H_MAX  = 12'hFFF;
  localparam logic [10:0] V_MAX  = 11'h7FF;

  // Edge detection and running counters
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [11:0] hcnt_q, hcnt_d, ha_acc_q, ha_acc_d, hs_acc_q, hs_acc_d;
  logic [11:0] line_len_q, line_len_d, ha_len_q, ha_len_d, hs_len_q, hs_len_d;
  logic [10:0] vcnt_q, vcnt_d, va_acc_q, va_acc_d, vs_acc_q, vs_acc_d;
  logic [10:0] vs_len_q, vs_len_d;
  logic        h_ovf_q, h_ovf_d, mismatch_q, mismatch_d;
  // Lock tracking
  logic [10:0] vt_slot_q [2];
  logic [10:0] vt_slot_d [2];
  logic [3:0]  lock_cnt_q, lock_cnt_d;
  logic        ref_valid_q, ref_valid_d;
  // Published set
  logic [11:0] h_total_q, h_total_d, h_active_q, h_active_d, h_sync_w_q, h_sync_w_d;
  logic [10:0] v_total_q, v_total_d, v_active_q, v_active_d, v_sync_w_q, v_sync_w_d;
  logic        field_q, field_d, interlaced_q, interlaced_d;
  logic        locked_q, locked_d, frame_stb_q, frame_stb_d;

  logic        hrise, hfall, vrise, vfall;
  logic [11:0] hcnt_step, new_len;
  logic        sat_h, sat_v, new_field, match;

  assign hrise = enable0 & hsync & ~hs_prev_q;
  assign hfall = enable0 & ~hsync & hs_prev_q;
  assign vrise = enable0 & vsync & ~vs_prev_q;
  assign vfall = enable0 & ~vsync & vs_prev_q;

  // hcnt after this sample; a line that ran to saturation is reported as 4095 long
  assign hcnt_step = hrise ? 12'd0 : ((hcnt_q == H_MAX) ? H_MAX : hcnt_q + 12'd1);
  assign new_len   = (hcnt_q == H_MAX) ? H_MAX : hcnt_q + 12'd1;

  // Next-state for counters, accumulators, the published set and lock control
  always_comb begin
    hs_prev_d    = hs_prev_q;    vs_prev_d    = vs_prev_q;
    hcnt_d       = hcnt_q;       ha_acc_d     = ha_acc_q;     hs_acc_d  = hs_acc_q;
    line_len_d   = line_len_q;   ha_len_d     = ha_len_q;     hs_len_d  = hs_len_q;
    vcnt_d       = vcnt_q;       va_acc_d     = va_acc_q;     vs_acc_d  = vs_acc_q;
    vs_len_d     = vs_len_q;     h_ovf_d      = h_ovf_q;      mismatch_d = mismatch_q;
    vt_slot_d[0] = vt_slot_q[0]; vt_slot_d[1] = vt_slot_q[1];
    lock_cnt_d   = lock_cnt_q;   ref_valid_d  = ref_valid_q;
    h_total_d    = h_total_q;    h_active_d   = h_active_q;   h_sync_w_d = h_sync_w_q;
    v_total_d    = v_total_q;    v_active_d   = v_active_q;   v_sync_w_d = v_sync_w_q;
    field_d      = field_q;      interlaced_d = interlaced_q;
    locked_d     = locked_q;     frame_stb_d  = 1'b0;
    sat_h        = 1'b0;         sat_v        = 1'b0;
    new_field    = 1'b0;         match        = 1'b0;

    if (enable0) begin
      hs_prev_d = hsync;
      vs_prev_d = vsync;
      hcnt_d    = hcnt_step;
      sat_h     = ~hrise & (hcnt_step == H_MAX);

      // Active pixels: the rise sample opens the new line's accumulation
      if (hrise) begin
        ha_len_d = ha_acc_q;
        ha_acc_d = {11'd0, ~hblank};
      end else if (~hblank && ha_acc_q != H_MAX) begin
        ha_acc_d = ha_acc_q + 12'd1;
      end

      if (hfall) begin
        hs_len_d = hs_acc_q;
        hs_acc_d = 12'd0;
      end else if (hsync && hs_acc_q != H_MAX) begin
        hs_acc_d = hs_acc_q + 12'd1;
      end

      if (hrise) begin
        line_len_d = new_len;
        if (new_len != line_len_q) mismatch_d = 1'b1;
        if (vcnt_q != V_MAX) vcnt_d = vcnt_q + 11'd1;
        if (~vblank && va_acc_q != V_MAX) va_acc_d = va_acc_q + 11'd1;
        if (vsync && vs_acc_q != V_MAX) vs_acc_d = vs_acc_q + 11'd1;
      end

      if (vfall) begin
        vs_len_d = vs_acc_q;
        vs_acc_d = 11'd0;
      end

      h_ovf_d = h_ovf_q | sat_h;

      // Publish: a coincident line is closed first (uses the _d values), but
      // its vcnt increment belongs to the frame that starts here
      if (vrise) begin
        new_field    = (hcnt_step >= {1'b0, line_len_d[11:1]});
        h_total_d    = line_len_d;
        h_active_d   = ha_len_d;
        h_sync_w_d   = hs_len_d;
        v_total_d    = vcnt_q;
        v_active_d   = va_acc_q;
        v_sync_w_d   = vs_len_d;
        field_d      = new_field;
        interlaced_d = new_field ^ field_q;
        frame_stb_d  = 1'b1;
        match = ref_valid_q && (line_len_d == h_total_q) &&
                (vcnt_q == vt_slot_q[new_field]) && ~mismatch_d && ~(h_ovf_q | sat_h);
        vt_slot_d[new_field] = vcnt_q;
        if (!match)                 lock_cnt_d = 4'd0;
        else if (lock_cnt_q < LOCK_N) lock_cnt_d = lock_cnt_q + 4'd1;
        locked_d     = (lock_cnt_d == LOCK_N);
        ref_valid_d  = 1'b1;
        vcnt_d       = {10'd0, hrise};
        va_acc_d     = {10'd0, hrise & ~vblank};
        mismatch_d   = 1'b0;
        h_ovf_d      = 1'b0;
      end

      // Loss of sync drops lock without touching the published set
      sat_v = (vcnt_d == V_MAX);
      if (sat_h || sat_v) begin
        locked_d   = 1'b0;
        lock_cnt_d = 4'd0;
      end
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_prev_q    <= 1'b0;  vs_prev_q    <= 1'b0;
      hcnt_q       <= '0;    ha_acc_q     <= '0;  hs_acc_q   <= '0;
      line_len_q   <= '0;    ha_len_q     <= '0;  hs_len_q   <= '0;
      vcnt_q       <= '0;    va_acc_q     <= '0;  vs_acc_q   <= '0;
      vs_len_q     <= '0;    h_ovf_q      <= 1'b0; mismatch_q <= 1'b0;
      vt_slot_q[0] <= '0;    vt_slot_q[1] <= '0;
      lock_cnt_q   <= '0;    ref_valid_q  <= 1'b0;
      h_total_q    <= '0;    h_active_q   <= '0;  h_sync_w_q <= '0;
      v_total_q    <= '0;    v_active_q   <= '0;  v_sync_w_q <= '0;
      field_q      <= 1'b0;  interlaced_q <= 1'b0;
      locked_q     <= 1'b0;  frame_stb_q  <= 1'b0;
    end else begin
      hs_prev_q    <= hs_prev_d;    vs_prev_q    <= vs_prev_d;
      hcnt_q       <= hcnt_d;       ha_acc_q     <= ha_acc_d;     hs_acc_q   <= hs_acc_d;
      line_len_q   <= line_len_d;   ha_len_q     <= ha_len_d;     hs_len_q   <= hs_len_d;
      vcnt_q       <= vcnt_d;       va_acc_q     <= va_acc_d;     vs_acc_q   <= vs_acc_d;
      vs_len_q     <= vs_len_d;     h_ovf_q      <= h_ovf_d;      mismatch_q <= mismatch_d;
      vt_slot_q[0] <= vt_slot_d[0]; vt_slot_q[1] <= vt_slot_d[1];
      lock_cnt_q   <= lock_cnt_d;   ref_valid_q  <= ref_valid_d;
      h_total_q    <= h_total_d;    h_active_q   <= h_active_d;   h_sync_w_q <= h_sync_w_d;
      v_total_q    <= v_total_d;    v_active_q   <= v_active_d;   v_sync_w_q <= v_sync_w_d;
      field_q      <= field_d;      interlaced_q <= interlaced_d;
      locked_q     <= locked_d;     frame_stb_q  <= frame_stb_d;
    end
  end

  assign h_total    = h_total_q;
  assign h_active   = h_active_q;
  assign h_sync_w   = h_sync_w_q;
  assign v_total    = v_total_q;
  assign v_active   = v_active_q;
  assign v_sync_w   = v_sync_w_q;
  assign field      = field_q;
  assign interlaced = interlaced_q;
  assign locked     = locked_q;
  assign frame_stb  = frame_stb_q;

endmodule
